// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the IF/MEM memory port arbiter.
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;
  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter tracking the fixed RAM latency of the access in flight.
module mem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         last,
  output logic         active
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (load)        cnt <= value;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last   = (cnt == W'(1));
  assign active = (cnt != '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency RAM port between instruction fetch and MEM stage;
// MEM has priority, IF is forced through after STARVE_MAX back-to-back MEM wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t state;
  owner_t     owner;
  logic       own_we, flushed;
  logic [3:0] streak;
  logic       lat_last, lat_active;
  logic       free, if_ok, force_if, gnt, done;

  mem_lat_counter #(.W(3)) u_lat (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (gnt),
    .value  (LAT),
    .last   (lat_last),
    .active (lat_active)
  );

  // The completion cycle frees the port so a new access can issue back-to-back.
  assign free     = !lat_active || lat_last;
  assign if_ok    = if_req && !if_flush;
  assign force_if = if_ok && (streak == SMAX);
  assign mem_gnt  = reset_n && free && mem_req && !force_if;
  assign if_gnt   = reset_n && free && if_ok && (force_if || !mem_req);
  assign gnt      = if_gnt || mem_gnt;
  assign done     = (state == ARB_WAIT) && lat_last;

  assign ram_en    = gnt;
  assign ram_we    = mem_gnt && mem_we;
  assign ram_addr  = mem_gnt ? mem_addr : (if_gnt ? if_addr : '0);
  assign ram_wdata = (mem_gnt && mem_we) ? mem_wdata : '0;

  // A flush landing in the completion cycle itself also suppresses the fetch.
  assign if_rvalid  = done && (owner == OWN_IF) && !flushed && !if_flush;
  assign mem_rvalid = done && (owner == OWN_MEM);
  assign if_rdata   = if_rvalid ? ram_rdata : '0;
  assign mem_rdata  = (mem_rvalid && !own_we) ? ram_rdata : '0;
  assign busy       = (state == ARB_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB_IDLE;
      owner   <= OWN_IF;
      own_we  <= 1'b0;
      flushed <= 1'b0;
      streak  <= '0;
    end else begin
      if (gnt) begin
        state   <= ARB_WAIT;
        owner   <= mem_gnt ? OWN_MEM : OWN_IF;
        own_we  <= mem_gnt && mem_we;
        flushed <= 1'b0;
      end else begin
        if (done) state <= ARB_IDLE;
        if (state == ARB_WAIT && owner == OWN_IF && if_flush) flushed <= 1'b1;
      end
      if (mem_gnt) begin
        if (!if_req)              streak <= '0;
        else if (streak != SMAX)  streak <= streak + 1'b1;
      end else if (if_gnt) begin
        streak <= '0;
      end
    end
  end
endmodule
